run_ctrl: RTL

Run-control sequencer for the processor: the DUT-side end of the START/DONE handshake. While START is high it holds the core in reset, clears data memory (one byte per cycle) and pulses a register-file clear. When START is released it runs the core until the decoder flags a halt instruction, then raises DONE and counts the cycles used. It sits in `toplevel` between the external START/DONE pins and the datapath (`dp`), and owns the data-memory write port during the clear sweep.

---
 rtl/run_ctrl_if.sv | 44 ++++
 rtl/run_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/run_ctrl_if.sv
// Run-control bundle between the external START/DONE pins, the core and the
// data-memory clear port. The master drives START/HALT; run_ctrl is the slave.
interface run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CYC_W  = 16
);
    logic              start;
    logic              halt;
    logic              done;
    logic              cpu_rst;
    logic              cpu_en;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;
    logic              rf_clr;
    logic [CYC_W-1:0]  cycle_count;

    modport master (
        output start,
        output halt,
        input  done,
        input  cpu_rst,
        input  cpu_en,
        input  clr_we,
        input  clr_addr,
        input  clr_data,
        input  rf_clr,
        input  cycle_count
    );

    modport slave (
        input  start,
        input  halt,
        output done,
        output cpu_rst,
        output cpu_en,
        output clr_we,
        output clr_addr,
        output clr_data,
        output rf_clr,
        output cycle_count
    );
endinterface

// File: rtl/run_ctrl.sv
// Run-control sequencer: holds the core in reset and sweeps data memory to
// zero while START is high, then runs the core until the decoder flags a
// halt, raising DONE and reporting how many cycles the run took.
// Every output is a flop, so nothing combinational reaches the pins.
module run_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int CYC_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    run_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARMED,
        RUN,
        FIN
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_e            state_q;
    logic              done_q;
    logic              cpuRst_q;
    logic              cpuEn_q;
    logic              clrWe_q;
    logic              rfClr_q;
    logic [ADDR_W-1:0] clrAddr_q;
    logic [CYC_W-1:0]  cycleCount_q;

    logic [ADDR_W-1:0] clrAddr_d;
    logic [CYC_W-1:0]  cycleCount_d;

    // Next sweep address and the saturating run-cycle increment.
    always_comb begin
        clrAddr_d    = clrAddr_q + 1'b1;
        cycleCount_d = cycleCount_q;
        if (cycleCount_q != {CYC_W{1'b1}}) begin
            cycleCount_d = cycleCount_q + 1'b1;
        end
    end

    // Sequencer: each edge picks the next state and loads that state's outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            cpuRst_q     <= 1'b1;
            cpuEn_q      <= 1'b0;
            clrWe_q      <= 1'b0;
            rfClr_q      <= 1'b0;
            clrAddr_q    <= '0;
            cycleCount_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q      <= CLEAR;
                        done_q       <= 1'b0;
                        cpuRst_q     <= 1'b1;
                        cpuEn_q      <= 1'b0;
                        clrWe_q      <= 1'b1;
                        rfClr_q      <= 1'b1;
                        clrAddr_q    <= '0;
                        cycleCount_q <= '0;
                    end
                end

                CLEAR: begin
                    rfClr_q <= 1'b0;
                    if (clrAddr_q == LAST_ADDR) begin
                        clrWe_q   <= 1'b0;
                        clrAddr_q <= '0;
                        if (bus.start) begin
                            state_q <= ARMED;
                        end else begin
                            state_q  <= RUN;
                            cpuRst_q <= 1'b0;
                            cpuEn_q  <= 1'b1;
                        end
                    end else begin
                        clrAddr_q <= clrAddr_d;
                    end
                end

                ARMED: begin
                    if (!bus.start) begin
                        state_q  <= RUN;
                        cpuRst_q <= 1'b0;
                        cpuEn_q  <= 1'b1;
                    end
                end

                RUN: begin
                    if (bus.start) begin
                        // Abort wins over a simultaneous halt.
                        state_q      <= CLEAR;
                        done_q       <= 1'b0;
                        cpuRst_q     <= 1'b1;
                        cpuEn_q      <= 1'b0;
                        clrWe_q      <= 1'b1;
                        rfClr_q      <= 1'b1;
                        clrAddr_q    <= '0;
                        cycleCount_q <= '0;
                    end else begin
                        cycleCount_q <= cycleCount_d;
                        if (bus.halt) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                            cpuEn_q <= 1'b0;
                        end
                    end
                end

                FIN: begin
                    if (bus.start) begin
                        state_q      <= CLEAR;
                        done_q       <= 1'b0;
                        cpuRst_q     <= 1'b1;
                        cpuEn_q      <= 1'b0;
                        clrWe_q      <= 1'b1;
                        rfClr_q      <= 1'b1;
                        clrAddr_q    <= '0;
                        cycleCount_q <= '0;
                    end
                end

                default: begin
                    state_q      <= IDLE;
                    done_q       <= 1'b0;
                    cpuRst_q     <= 1'b1;
                    cpuEn_q      <= 1'b0;
                    clrWe_q      <= 1'b0;
                    rfClr_q      <= 1'b0;
                    clrAddr_q    <= '0;
                    cycleCount_q <= '0;
                end
            endcase
        end
    end

    assign bus.done        = done_q;
    assign bus.cpu_rst     = cpuRst_q;
    assign bus.cpu_en      = cpuEn_q;
    assign bus.clr_we      = clrWe_q;
    assign bus.clr_addr    = clrAddr_q;
    assign bus.clr_data    = {DATA_W{1'b0}};
    assign bus.rf_clr      = rfClr_q;
    assign bus.cycle_count = cycleCount_q;

endmodule
